// File: rtl/matrix_cfg_loader_if.sv
// ---------------------------------------------------------------------------
// matrix_cfg_loader_if
// Serial configuration link between a bitstream source and matrix_cfg_loader.
//   cfg_bit   : serial data, MSB-first per item
//   cfg_valid : cfg_bit is valid this cycle
//   cfg_ready : loader accepts cfg_bit (transfer when valid && ready)
//   cfg_abort : drop the frame in progress and resume hunting for a header
// master = bitstream source, slave = loader.
// ---------------------------------------------------------------------------
interface matrix_cfg_loader_if;
    logic cfg_bit;
    logic cfg_valid;
    logic cfg_ready;
    logic cfg_abort;

    modport master (
        output cfg_bit,
        output cfg_valid,
        output cfg_abort,
        input  cfg_ready
    );

    modport slave (
        input  cfg_bit,
        input  cfg_valid,
        input  cfg_abort,
        output cfg_ready
    );
endinterface

// File: rtl/matrix_cfg_loader.sv
// ---------------------------------------------------------------------------
// matrix_cfg_loader
// Receives a framed serial configuration bitstream, assembles the 18 route
// select fields of the 5x4 switch matrix in a shadow register, verifies the
// XOR checksum and the legality of every field, and commits the whole set to
// the active select registers in one clock edge.
//
// Frame: SYNC_WORD (8b) | top0..top4, bottom0..bottom4, left0..left3,
//        right0..right3 (18 x FIELD_W) | checksum (FIELD_W) ; MSB-first.
//
// Ports:
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   cfg_if     : serial link (slave side): cfg_bit/cfg_valid/cfg_abort in,
//                cfg_ready out
//   cfg_top    : active top fields, field i at [i*FIELD_W +: FIELD_W]
//   cfg_bottom : active bottom fields
//   cfg_left   : active left fields
//   cfg_right  : active right fields
//   cfg_done   : one-cycle pulse after a successful commit
//   cfg_err    : sticky flags, bit0 checksum mismatch, bit1 illegal field
//   cfg_busy   : registered, low only while hunting for a header
//   cfg_loaded : a frame has committed since reset
// ---------------------------------------------------------------------------
module matrix_cfg_loader #(
    parameter int          N_TOP     = 5,
    parameter int          N_SIDE    = 4,
    parameter int          FIELD_W   = 6,
    parameter logic [7:0]  SYNC_WORD = 8'hA5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    matrix_cfg_loader_if.slave          cfg_if,
    output logic [N_TOP*FIELD_W-1:0]    cfg_top,
    output logic [N_TOP*FIELD_W-1:0]    cfg_bottom,
    output logic [N_SIDE*FIELD_W-1:0]   cfg_left,
    output logic [N_SIDE*FIELD_W-1:0]   cfg_right,
    output logic                        cfg_done,
    output logic [1:0]                  cfg_err,
    output logic                        cfg_busy,
    output logic                        cfg_loaded
);

    localparam int N_FIELDS = 2 * N_TOP + 2 * N_SIDE;
    localparam int SHADOW_W = N_FIELDS * FIELD_W;
    localparam int CNT_W    = $clog2(SHADOW_W);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LOAD,
        ST_CHK,
        ST_COMMIT
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [7:0]                  r_window;
    logic [7:0]                  w_window_next;
    logic [7:0]                  w_window_shift;
    logic [SHADOW_W-1:0]         r_shadow;
    logic [SHADOW_W-1:0]         w_shadow_next;
    logic [FIELD_W-1:0]          r_csum;
    logic [FIELD_W-1:0]          w_csum_next;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_cnt_next;
    logic                        w_ready;
    logic                        w_accept;
    logic                        w_commit;
    logic [1:0]                  w_err_set;

    logic [N_TOP*FIELD_W-1:0]    r_top;
    logic [N_TOP*FIELD_W-1:0]    r_bottom;
    logic [N_SIDE*FIELD_W-1:0]   r_left;
    logic [N_SIDE*FIELD_W-1:0]   r_right;
    logic                        r_done;
    logic [1:0]                  r_err;
    logic                        r_busy;
    logic                        r_loaded;

    logic [FIELD_W-1:0]          w_field [N_FIELDS];
    logic [N_FIELDS-1:0]         w_field_ok;
    logic [FIELD_W-1:0]          w_xor;
    logic                        w_csum_ok;
    logic                        w_legal_ok;
    logic [N_TOP*FIELD_W-1:0]    w_top_new;
    logic [N_TOP*FIELD_W-1:0]    w_bottom_new;
    logic [N_SIDE*FIELD_W-1:0]   w_left_new;
    logic [N_SIDE*FIELD_W-1:0]   w_right_new;

    // Field legality: low bits are the direction code, high bits the wire
    // index on the source edge. Directions 1/3 address the 5-wire top/bottom
    // edges, 2/4 the 4-wire left/right edges, 0 means undriven.
    function automatic logic f_field_legal(input logic [FIELD_W-1:0] f);
        logic [2:0]         dir;
        logic [FIELD_W-4:0] idx;
        dir = f[2:0];
        idx = f[FIELD_W-1:3];
        case (dir)
            3'd0:       f_field_legal = 1'b1;
            3'd1, 3'd3: f_field_legal = (int'(idx) < N_TOP);
            3'd2, 3'd4: f_field_legal = (int'(idx) < N_SIDE);
            default:    f_field_legal = 1'b0;
        endcase
    endfunction

    // The first field received ends up in the most significant slot of the
    // shadow, so field k sits at the k-th FIELD_W slice from the top.
    genvar gi;
    generate
        for (gi = 0; gi < N_FIELDS; gi++) begin : g_field
            assign w_field[gi]    = r_shadow[SHADOW_W-1-gi*FIELD_W -: FIELD_W];
            assign w_field_ok[gi] = f_field_legal(w_field[gi]);
        end
        for (gi = 0; gi < N_TOP; gi++) begin : g_tb_pack
            assign w_top_new[gi*FIELD_W +: FIELD_W]    = w_field[gi];
            assign w_bottom_new[gi*FIELD_W +: FIELD_W] = w_field[N_TOP+gi];
        end
        for (gi = 0; gi < N_SIDE; gi++) begin : g_lr_pack
            assign w_left_new[gi*FIELD_W +: FIELD_W]  = w_field[2*N_TOP+gi];
            assign w_right_new[gi*FIELD_W +: FIELD_W] = w_field[2*N_TOP+N_SIDE+gi];
        end
    endgenerate

    always_comb begin
        w_xor = '0;
        for (int k = 0; k < N_FIELDS; k++) begin
            w_xor = w_xor ^ w_field[k];
        end
    end

    assign w_csum_ok      = (w_xor == r_csum);
    assign w_legal_ok     = &w_field_ok;
    assign w_ready        = (r_state != ST_COMMIT);
    assign w_accept       = cfg_if.cfg_valid && w_ready;
    assign w_window_shift = {r_window[6:0], cfg_if.cfg_bit};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        w_state_next  = r_state;
        w_window_next = r_window;
        w_shadow_next = r_shadow;
        w_csum_next   = r_csum;
        w_cnt_next    = r_cnt;
        w_commit      = 1'b0;
        w_err_set     = 2'b00;
        case (r_state)
            ST_HUNT: begin
                if (cfg_if.cfg_abort) begin
                    w_window_next = '0;
                end else if (w_accept) begin
                    w_window_next = w_window_shift;
                    if (w_window_shift == SYNC_WORD) begin
                        w_state_next = ST_LOAD;
                        w_cnt_next   = '0;
                    end
                end
            end
            ST_LOAD: begin
                if (cfg_if.cfg_abort) begin
                    w_state_next  = ST_HUNT;
                    w_window_next = '0;
                end else if (w_accept) begin
                    w_shadow_next = {r_shadow[SHADOW_W-2:0], cfg_if.cfg_bit};
                    if (r_cnt == CNT_W'(SHADOW_W - 1)) begin
                        w_state_next = ST_CHK;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_CHK: begin
                if (cfg_if.cfg_abort) begin
                    w_state_next  = ST_HUNT;
                    w_window_next = '0;
                end else if (w_accept) begin
                    w_csum_next = {r_csum[FIELD_W-2:0], cfg_if.cfg_bit};
                    if (r_cnt == CNT_W'(FIELD_W - 1)) begin
                        w_state_next = ST_COMMIT;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                w_state_next  = ST_HUNT;
                w_window_next = '0;
                // An abort in the commit cycle suppresses both the commit
                // and any error update.
                if (!cfg_if.cfg_abort) begin
                    if (w_csum_ok && w_legal_ok) begin
                        w_commit = 1'b1;
                    end else begin
                        w_err_set = {~w_legal_ok, ~w_csum_ok};
                    end
                end
            end
            default: begin
                w_state_next = ST_HUNT;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_window <= '0;
            r_shadow <= '0;
            r_csum   <= '0;
            r_cnt    <= '0;
            r_top    <= '0;
            r_bottom <= '0;
            r_left   <= '0;
            r_right  <= '0;
            r_done   <= 1'b0;
            r_err    <= 2'b00;
            r_busy   <= 1'b0;
            r_loaded <= 1'b0;
        end else begin
            r_window <= w_window_next;
            r_shadow <= w_shadow_next;
            r_csum   <= w_csum_next;
            r_cnt    <= w_cnt_next;
            r_busy   <= (w_state_next != ST_HUNT);
            r_done   <= w_commit;
            if (w_commit) begin
                r_top    <= w_top_new;
                r_bottom <= w_bottom_new;
                r_left   <= w_left_new;
                r_right  <= w_right_new;
                r_loaded <= 1'b1;
                r_err    <= 2'b00;
            end else begin
                r_err <= r_err | w_err_set;
            end
        end
    end

    assign cfg_if.cfg_ready = w_ready;
    assign cfg_top          = r_top;
    assign cfg_bottom       = r_bottom;
    assign cfg_left         = r_left;
    assign cfg_right        = r_right;
    assign cfg_done         = r_done;
    assign cfg_err          = r_err;
    assign cfg_busy         = r_busy;
    assign cfg_loaded       = r_loaded;

endmodule

// File: tb/tb_matrix_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_matrix_cfg_loader
// Drives framed bitstreams (directed and random, with idle gaps, garbage,
// aborts and resets) and checks every cycle against a frame-level model that
// collects accepted bits into a queue and decodes the frame arithmetically.
// ---------------------------------------------------------------------------
module tb_matrix_cfg_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] cfg_top;
    logic [29:0] cfg_bottom;
    logic [23:0] cfg_left;
    logic [23:0] cfg_right;
    logic        cfg_done;
    logic [1:0]  cfg_err;
    logic        cfg_busy;
    logic        cfg_loaded;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    matrix_cfg_loader_if ifc ();

    matrix_cfg_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_if     (ifc),
        .cfg_top    (cfg_top),
        .cfg_bottom (cfg_bottom),
        .cfg_left   (cfg_left),
        .cfg_right  (cfg_right),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .cfg_busy   (cfg_busy),
        .cfg_loaded (cfg_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [29:0] m_top = '0, m_bot = '0;
    logic [23:0] m_left = '0, m_right = '0;
    logic        m_done = 1'b0, m_busy = 1'b0, m_loaded = 1'b0;
    logic [1:0]  m_err = 2'b00;
    bit          m_in_frame = 1'b0;
    logic [7:0]  m_win = '0;
    bit          fq[$];

    function automatic bit legal_field(input logic [5:0] f);
        int dir, idx, lim;
        dir = int'(f[2:0]);
        idx = int'(f[5:3]);
        case (dir)
            0:       lim = 8;
            1, 3:    lim = 5;
            2, 4:    lim = 4;
            default: lim = 0;
        endcase
        return idx < lim;
    endfunction

    always @(posedge clk) begin : model
        logic [5:0] f [18];
        logic [5:0] cs, x;
        bit ok_leg, rdy, acc;
        if (!rst_n) begin
            m_top = '0; m_bot = '0; m_left = '0; m_right = '0;
            m_done = 0; m_busy = 0; m_loaded = 0; m_err = 0;
            m_in_frame = 0; m_win = 0; fq.delete();
        end else begin
            rdy = !(m_in_frame && fq.size() == 114);
            acc = ifc.cfg_valid && rdy;
            m_done = 0;
            if (!m_in_frame) begin
                if (ifc.cfg_abort) m_win = 0;
                else if (acc) begin
                    m_win = {m_win[6:0], ifc.cfg_bit};
                    if (m_win == 8'hA5) begin
                        m_in_frame = 1;
                        fq.delete();
                    end
                end
            end else if (ifc.cfg_abort) begin
                m_in_frame = 0;
                m_win = 0;
            end else if (fq.size() == 114) begin
                x = 0;
                ok_leg = 1;
                for (int k = 0; k < 18; k++) begin
                    f[k] = 0;
                    for (int j = 0; j < 6; j++) f[k] = (f[k] << 1) | 6'(fq[6*k+j]);
                    x = x ^ f[k];
                    if (!legal_field(f[k])) ok_leg = 0;
                end
                cs = 0;
                for (int j = 0; j < 6; j++) cs = (cs << 1) | 6'(fq[108+j]);
                if (x == cs && ok_leg) begin
                    for (int i = 0; i < 5; i++) begin
                        m_top[6*i +: 6] = f[i];
                        m_bot[6*i +: 6] = f[5+i];
                    end
                    for (int i = 0; i < 4; i++) begin
                        m_left[6*i +: 6]  = f[10+i];
                        m_right[6*i +: 6] = f[14+i];
                    end
                    m_loaded = 1;
                    m_err = 0;
                    m_done = 1;
                end else begin
                    if (x != cs) m_err[0] = 1;
                    if (!ok_leg) m_err[1] = 1;
                end
                m_in_frame = 0;
                m_win = 0;
            end else if (acc) begin
                fq.push_back(ifc.cfg_bit);
            end
            m_busy = m_in_frame;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("top",    64'(cfg_top),    64'(m_top));
            check("bottom", 64'(cfg_bottom), 64'(m_bot));
            check("left",   64'(cfg_left),   64'(m_left));
            check("right",  64'(cfg_right),  64'(m_right));
            check("done",   64'(cfg_done),   64'(m_done));
            check("err",    64'(cfg_err),    64'(m_err));
            check("busy",   64'(cfg_busy),   64'(m_busy));
            check("loaded", 64'(cfg_loaded), 64'(m_loaded));
            check("ready",  64'(ifc.cfg_ready), 64'(!(m_in_frame && fq.size() == 114)));
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [5:0] g_f [18];

    function automatic logic [107:0] pack_fields();
        logic [107:0] v;
        for (int k = 0; k < 18; k++) v[107-6*k -: 6] = g_f[k];
        return v;
    endfunction

    function automatic logic [5:0] cs_of();
        logic [5:0] x;
        x = 0;
        for (int k = 0; k < 18; k++) x = x ^ g_f[k];
        return x;
    endfunction

    function automatic bit all_legal();
        bit ok;
        ok = 1;
        for (int k = 0; k < 18; k++) if (!legal_field(g_f[k])) ok = 0;
        return ok;
    endfunction

    task automatic clear_fields();
        for (int k = 0; k < 18; k++) g_f[k] = 6'd0;
    endtask

    task automatic rand_fields(input bit allow_bad);
        int dir, lim, idx, pos;
        for (int k = 0; k < 18; k++) begin
            dir = $urandom_range(0, 4);
            lim = (dir == 0) ? 8 : ((dir == 1 || dir == 3) ? 5 : 4);
            idx = $urandom_range(0, lim - 1);
            g_f[k] = {3'(idx), 3'(dir)};
        end
        if (allow_bad && $urandom_range(0, 4) == 0) begin
            pos = $urandom_range(0, 17);
            g_f[pos][2:0] = 3'($urandom_range(5, 7));
        end
    endtask

    // Present one bit until it is accepted; optional idle cycles first.
    task automatic drive_bit(input logic b, input int gap_pct);
        int tries;
        while ($urandom_range(0, 99) < gap_pct) begin
            ifc.cfg_valid = 1'b0;
            @(posedge clk); #1;
        end
        ifc.cfg_valid = 1'b1;
        ifc.cfg_bit   = b;
        tries = 0;
        while (ifc.cfg_ready !== 1'b1 && tries < 4) begin
            @(posedge clk); #1;
            tries++;
        end
        n_checks++;
        if (tries >= 4) begin
            n_errors++;
            $display("FAIL ready_timeout: ready stuck at %0b expected 1 at %0t", ifc.cfg_ready, $time);
        end
        @(posedge clk); #1;
        ifc.cfg_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [127:0] v, input int n, input int gap_pct);
        for (int i = n - 1; i >= 0; i--) drive_bit(v[i], gap_pct);
    endtask

    task automatic send_frame(input logic [5:0] cs, input int gap_pct,
                              input bit chk_done, input bit exp_commit);
        logic [127:0] v;
        v = {6'd0, 8'hA5, pack_fields(), cs};
        send_bits(v, 122, gap_pct);
        if (chk_done) begin
            // Now in the cycle after the last checksum bit was accepted.
            check("done_at_T1", 64'(cfg_done), 64'd0);
            check("ready_in_commit", 64'(ifc.cfg_ready), 64'd0);
            @(posedge clk); #1;
            check("done_at_T2", 64'(cfg_done), 64'(exp_commit));
            @(posedge clk); #1;
            check("done_width", 64'(cfg_done), 64'd0);
        end
    endtask

    task automatic abort_cycle();
        ifc.cfg_abort = 1'b1;
        ifc.cfg_valid = 1'b1;
        ifc.cfg_bit   = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        ifc.cfg_abort = 1'b0;
        ifc.cfg_valid = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [5:0]   cs;
        logic [127:0] v;
        int           n;
        ifc.cfg_bit   = 1'b0;
        ifc.cfg_valid = 1'b0;
        ifc.cfg_abort = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_top",    64'(cfg_top),    64'd0);
        check("rst_loaded", 64'(cfg_loaded), 64'd0);
        check("rst_err",    64'(cfg_err),    64'd0);
        check("rst_busy",   64'(cfg_busy),   64'd0);
        check("rst_ready",  64'(ifc.cfg_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All-zero frame
        clear_fields();
        send_frame(6'd0, 0, 1'b1, 1'b1);
        check("zero_loaded", 64'(cfg_loaded), 64'd1);
        check("zero_err",    64'(cfg_err),    64'd0);
        check("zero_top",    64'(cfg_top),    64'd0);

        // top0 from right[0], right3 from top[4]
        clear_fields();
        g_f[0]  = 6'b000_010;
        g_f[17] = 6'b100_001;
        check("cs_model", 64'(cs_of()), 64'(6'b100_011));
        send_frame(6'b100_011, 0, 1'b1, 1'b1);
        check("t2_top0",   64'(cfg_top[5:0]),    64'(6'b000_010));
        check("t2_right3", 64'(cfg_right[23:18]), 64'(6'b100_001));
        check("t2_top_rest", 64'(cfg_top[29:6]), 64'd0);
        check("t2_err",    64'(cfg_err),         64'd0);

        // Illegal direction 5 in left1
        clear_fields();
        g_f[11] = 6'b000_101;
        send_frame(cs_of(), 0, 1'b1, 1'b0);
        check("ill_err",  64'(cfg_err), 64'(2'b10));
        check("ill_keep", 64'(cfg_right[23:18]), 64'(6'b100_001));
        clear_fields();
        g_f[3] = 6'b011_011;
        send_frame(cs_of(), 0, 1'b1, 1'b1);
        check("ill_clr_err", 64'(cfg_err), 64'd0);
        check("ill_clr_top3", 64'(cfg_top[23:18]), 64'(6'b011_011));

        // Bad checksum
        clear_fields();
        g_f[0]  = 6'b000_010;
        g_f[17] = 6'b100_001;
        send_frame(6'd0, 0, 1'b1, 1'b0);
        check("cs_err",  64'(cfg_err), 64'(2'b01));
        check("cs_keep", 64'(cfg_top[23:18]), 64'(6'b011_011));

        // Garbage then a valid frame with random gaps
        send_bits(128'h5A, 8, 30);
        rand_fields(1'b0);
        send_frame(cs_of(), 30, 1'b1, 1'b1);
        check("garb_err", 64'(cfg_err), 64'd0);

        // Abort at LOAD bit 50
        v = 128'h0;
        v[57:50] = 8'hA5;
        send_bits(v, 58, 0);
        abort_cycle();
        check("abort_busy", 64'(cfg_busy), 64'd0);
        @(posedge clk); #1;
        check("abort_nodone", 64'(cfg_done), 64'd0);

        // Random frames with gaps, garbage, occasional bad frames and aborts
        for (int r = 0; r < 24; r++) begin
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) drive_bit(1'($urandom_range(0, 1)), 20);
            rand_fields(1'b1);
            cs = cs_of();
            if ($urandom_range(0, 4) == 0) cs = cs ^ 6'($urandom_range(1, 63));
            if ($urandom_range(0, 5) == 0) begin
                v = {6'd0, 8'hA5, pack_fields(), cs};
                n = $urandom_range(1, 121);
                for (int i = 121; i > 121 - n; i--) drive_bit(v[i], 20);
                abort_cycle();
            end else begin
                send_frame(cs, $urandom_range(0, 40), 1'b0, 1'b0);
            end
            repeat (2) @(posedge clk);
            #1;
        end

        // Known commit, then reset in the middle of the checksum
        clear_fields();
        g_f[0]  = 6'b000_010;
        g_f[17] = 6'b100_001;
        send_frame(6'b100_011, 0, 1'b1, 1'b1);
        check("pre_rst_loaded", 64'(cfg_loaded), 64'd1);
        v = {6'd0, 8'hA5, pack_fields(), 6'b100_011};
        for (int i = 121; i >= 3; i--) drive_bit(v[i], 0);
        check("chk_busy", 64'(cfg_busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_loaded", 64'(cfg_loaded), 64'd0);
        check("mid_rst_top",    64'(cfg_top),    64'd0);
        check("mid_rst_right",  64'(cfg_right),  64'd0);
        check("mid_rst_busy",   64'(cfg_busy),   64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rand_fields(1'b0);
        send_frame(cs_of(), 10, 1'b1, 1'b1);
        check("post_rst_loaded", 64'(cfg_loaded), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/matrix_cfg_loader.md
Name: matrix_cfg_loader

Overview:
Serial configuration loader that sits directly upstream of the 5x4 switch-matrix tile. It receives a framed configuration bitstream over a valid/ready serial link and assembles the 18 six-bit route-select fields in a shadow register. It checks the checksum and the field legality, then commits the fields atomically to the registers that drive the matrix's top/bottom/left/right select inputs. The active configuration never shows a partially loaded frame.

Parameters:
N_TOP, 5, wires on the top and on the bottom edge
N_SIDE, 4, wires on the left and on the right edge
FIELD_W, 6, select field width: [2:0] direction code, [5:3] wire index
SYNC_WORD, 8'hA5, frame header pattern

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous, active-low reset
cfg_bit  in  1  serial config data
cfg_valid  in  1  cfg_bit is valid this cycle
cfg_ready  out  1  loader accepts cfg_bit; a transfer occurs when valid&&ready
cfg_abort  in  1  discard the frame in progress and return to HUNT
cfg_top  out  N_TOP*FIELD_W  active top fields; field i at [i*FIELD_W +: FIELD_W]
cfg_bottom  out  N_TOP*FIELD_W  active bottom fields, same packing
cfg_left  out  N_SIDE*FIELD_W  active left fields, same packing
cfg_right  out  N_SIDE*FIELD_W  active right fields, same packing
cfg_done  out  1  one-cycle pulse when a frame commits
cfg_err  out  2  sticky error flags: bit0 checksum mismatch, bit1 illegal field
cfg_busy  out  1  high when state != HUNT
cfg_loaded  out  1  high once any frame has committed since reset

Behaviour:
- Reset (rst_n=0 at a clk edge): all cfg_* field outputs 0 (every matrix wire undriven), shadow register 0, cfg_done=0, cfg_err=0, cfg_loaded=0, state=HUNT. Reset wins over every other input, including in the middle of a frame.
- Frame format, MSB-first within each item: SYNC_WORD (8 bits), then 18 fields in the order top0..top4, bottom0..bottom4, left0..left3, right0..right3 (108 bits), then a 6-bit checksum equal to the XOR of all 18 fields.
- A bit is consumed only on a cycle where cfg_valid && cfg_ready. Idle cycles (cfg_valid=0) are allowed anywhere in the frame.
- cfg_ready=1 in HUNT, LOAD and CHK. cfg_ready=0 in COMMIT.
- States:
  - HUNT: shift each accepted bit into an 8-bit sliding window. When the window including the current bit equals SYNC_WORD, move to LOAD with the bit counter at 0. The window clears on entry to HUNT.
  - LOAD: shift each accepted bit into the 108-bit shadow register. On the bit that brings the count to 108, move to CHK with the counter cleared.
  - CHK: shift in the 6 checksum bits. After the 6th bit, move to COMMIT.
  - COMMIT: one cycle, then HUNT. Compute the XOR of all shadow fields and compare it with the received checksum. Check legality of every field:
    - dir 0: always legal.
    - dir 1 or 3: legal only if idx < N_TOP.
    - dir 2 or 4: legal only if idx < N_SIDE.
    - dir 5..7: illegal.
  - COMMIT, both checks pass: at the end of the COMMIT cycle, load all four cfg_* buses from the shadow, set cfg_loaded=1, clear cfg_err to 0. cfg_done is high for exactly the next cycle.
  - COMMIT, a check fails: cfg_* buses are unchanged, cfg_done stays 0. Set cfg_err bit0 and/or bit1 (OR into the sticky flags).
- Latency: if the last checksum bit is accepted in cycle T, COMMIT occupies cycle T+1, and the new cfg_* values and cfg_done are visible in cycle T+2.
- cfg_abort=1 in LOAD, CHK or COMMIT: go to HUNT at the next edge. Nothing commits, cfg_err is unchanged, and any bit presented in the same cycle is discarded. cfg_abort=1 in HUNT clears the sync window.
- cfg_busy is a registered state decode: 0 only in HUNT.
- Bits beyond a frame are simply hunted; a new frame may start immediately after COMMIT.

Test Plan:
- Reset, then frame A5 + 108 zeros + checksum 000000 -> cfg_done pulses 1 cycle 2 cycles after the last bit; all buses 0; cfg_loaded=1; cfg_err=00.
- Frame with top0=6'b000_010 (top0 driven from right[0]) and right3=6'b100_001 (right3 driven from top[4]), checksum 6'b100_011 -> cfg_top[5:0]=000010, cfg_right[23:18]=100001, all other fields 0.
- Same frame but with checksum 000000 -> no cfg_done, cfg_err=01, buses keep the previous contents.
- Field left1=6'b000_101 (dir 5) with correct checksum -> cfg_err=10, no commit. A following valid frame -> commit, cfg_err=00.
- Garbage bits 0x5A then A5 + valid frame, with random cfg_valid gaps -> frame is found and commits correctly. cfg_abort asserted at LOAD bit 50 -> cfg_busy=0 next cycle, no commit.
- rst_n=0 during CHK after a prior commit -> all buses 0, cfg_loaded=0. The next full frame commits normally.
